aeolus_multicycle_core: RTL and testbench
=========================================

// Module: aeolus_multicycle_core
// PURPOSE
//  Next-generation Aeolus CPU core: parametrised accumulator machine with a FETCH/DECODE/EXECUTE FSM.
//  Adds branches, halt, carry/zero flags and ready/valid handshakes on data in/out.
//  Instantiated by the board top. Clock divider, instruction ROM and 7-seg driver stay outside the core.
// PARAMETERS
//  DATA_WIDTH  8  width of A, B, ACC, O, inData, outData
//  ADDR_WIDTH  5  PC / ROM address width; also operand width
//  INSTR_WIDTH 4+ADDR_WIDTH  instruction = {opcode[3:0], operand[ADDR_WIDTH-1:0]}
// PORTS
//  clk        in   1            core clock
//  reset      in   1            synchronous, active-high
//  instrAddr  out  ADDR_WIDTH   ROM address (= PC)
//  instrData  in   INSTR_WIDTH  ROM data, valid 1 cycle after instrAddr (sync ROM)
//  inData     in   DATA_WIDTH   input operand (switches)
//  inValid    in   1            inData valid
//  inReady    out  1            core accepting inData
//  outData    out  DATA_WIDTH   O register
//  outValid   out  1            outData offered
//  outReady   in   1            consumer accepts outData
//  halted     out  1            core in HALT
// BEHAVIOUR
//  Reset: PC, IR, A, B, ACC, O, Z, C = 0; state=FETCH; inReady=outValid=halted=0. Reset wins over all events, mid-handshake included.
//  States:
//   FETCH: instrAddr=PC -> DECODE.
//   DECODE: IR<=instrData; PC<=PC+1 mod 2^ADDR_WIDTH (31->0 wraps) -> EXEC.
//   EXEC: perform op -> FETCH, except as noted for LDA/LDB, OUT, HLT.
//  Latency: every non-stalling instruction takes exactly 3 cycles.
//  Opcodes; ACC results also set Z=(ACC_next==0):
//   0 NOP
//   1 LDA  -> WAIT_IN, target A
//   2 LDB  -> WAIT_IN, target B
//   3 LDI  ACC<=zero-ext operand (truncate if wider than DATA_WIDTH)
//   4 ADD  {C,ACC}<=A+B
//   5 SUB  ACC<=A-B; C=borrow (A<B)
//   6 AND  ACC<=A&B
//   7 OR   ACC<=A|B
//   8 XOR  ACC<=A^B
//   9 INV  ACC<=~A
//   A LSH  C<=ACC[MSB]; ACC<=ACC<<1
//   B RSH  C<=ACC[0]; ACC>>1 (logical)
//   C OUT  O<=ACC -> WAIT_OUT
//   D JMP  PC<=operand
//   E JNZ  if !Z then PC<=operand, else PC unchanged
//   F HLT  -> HALT
//  C is unchanged by 6-9 and 3.
//  WAIT_IN:
//   inReady=1. On inValid&&inReady: target<=inData; -> FETCH.
//   Stays indefinitely while inValid=0.
//  WAIT_OUT:
//   outValid=1; outData stable (=O).
//   On outReady -> FETCH; outValid drops the next cycle.
//   outReady high on the entry cycle completes in 1 cycle.
//  HALT: halted=1; all registers frozen; only reset exits.
//  outData always = O. inReady/outValid are 0 outside their wait states.
//  Branch to the current PC (self-loop) is legal and spins forever.
//  JMP issued at address 2^ADDR_WIDTH-1 overrides the wrap.
// CONFIGURATION
//  AEOLUS_SINGLE_STEP_EN defined:
//   Adds input port 'step' (1 bit). FETCH holds until step=1.
//   Exactly one instruction per step cycle; halted behaviour unchanged.
//  AEOLUS_SINGLE_STEP_EN undefined:
//   No step port; FETCH always advances after 1 cycle.
// TESTING
//  1 Reset:
//    reset 2 cycles mid-WAIT_OUT -> all regs 0, outValid=0, instrAddr=0 next cycle.
//  2 Arithmetic:
//    LDA(inData=0xF0), LDB(0x20), ADD; OUT with outReady=1
//    -> outData=0x10, C=1, Z=0.
//    Then SUB with A=0x20, B=0x20 -> ACC=0, Z=1, C=0.
//  3 Branch:
//    LDI 3, LSH, JNZ 5 -> PC=5, ACC=0x06.
//    LDI 0, JNZ 5 -> falls through. JMP at PC=31 to 0 -> fetch addr 0.
//  4 Handshake:
//    LDA with inValid low 10 cycles -> inReady=1 throughout, A unchanged.
//    inValid=1 -> A=inData, inReady=0 next cycle.
//    OUT with outReady low 5 cycles -> outValid held, outData stable.
//  5 Wrap/halt:
//    NOP at addr 31 -> next fetch addr 0.
//    HLT -> halted=1; registers unchanged for 20 cycles.
//  6 Macro on:
//    step pulsed every 4th cycle -> exactly one instruction retires per pulse.

Source files
------------

// File: rtl/aeolus_multicycle_core.sv
// Aeolus multicycle accumulator core: FETCH/DECODE/EXEC FSM with branches, halt, C/Z flags and in/out handshakes.
// Optional single-step gating of FETCH via macro AEOLUS_SINGLE_STEP_EN (adds input port 'step').
module aeolus_multicycle_core #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned INSTR_WIDTH = 4 + ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef AEOLUS_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [ADDR_WIDTH-1:0]  instrAddr,
    input  logic [INSTR_WIDTH-1:0] instrData,
    input  logic [DATA_WIDTH-1:0]  inData,
    input  logic                   inValid,
    output logic                   inReady,
    output logic [DATA_WIDTH-1:0]  outData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_IN,
        S_WAIT_OUT,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LDI = 4'h3,
        OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_XOR = 4'h8, OP_INV = 4'h9, OP_LSH = 4'hA, OP_RSH = 4'hB,
        OP_OUT = 4'hC, OP_JMP = 4'hD, OP_JNZ = 4'hE, OP_HLT = 4'hF
    } op_e;

    state_e                  state;
    state_e                  state_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [INSTR_WIDTH-1:0]  ir;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   o;
    logic                    z;
    logic                    c;

    op_e                     opcode;
    logic [ADDR_WIDTH-1:0]   operand;
    logic                    step_ok;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_c;
    logic                    alu_we;
    logic                    c_we;

    assign opcode  = op_e'(ir[INSTR_WIDTH-1:ADDR_WIDTH]);
    assign operand = ir[ADDR_WIDTH-1:0];
    assign sum     = {1'b0, a} + {1'b0, b};

`ifdef AEOLUS_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (step_ok) state_next = S_DECODE;
            S_DECODE:   state_next = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LDA, OP_LDB: state_next = S_WAIT_IN;
                    OP_OUT:         state_next = S_WAIT_OUT;
                    OP_HLT:         state_next = S_HALT;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_WAIT_IN:  if (inValid) state_next = S_FETCH;
            S_WAIT_OUT: if (outReady) state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        instrAddr = pc;
        outData   = o;
        inReady   = (state == S_WAIT_IN);
        outValid  = (state == S_WAIT_OUT);
        halted    = (state == S_HALT);
    end

    // ALU result and flag-write enables; C is only written by ADD/SUB/LSH/RSH.
    always_comb begin
        alu_res = acc;
        alu_c   = c;
        alu_we  = 1'b1;
        c_we    = 1'b0;
        case (opcode)
            OP_LDI: alu_res = DATA_WIDTH'(operand);
            OP_ADD: begin
                alu_res = sum[DATA_WIDTH-1:0];
                alu_c   = sum[DATA_WIDTH];
                c_we    = 1'b1;
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_c   = (a < b);
                c_we    = 1'b1;
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_INV: alu_res = ~a;
            OP_LSH: begin
                alu_res = acc << 1;
                alu_c   = acc[DATA_WIDTH-1];
                c_we    = 1'b1;
            end
            OP_RSH: begin
                alu_res = acc >> 1;
                alu_c   = acc[0];
                c_we    = 1'b1;
            end
            default: alu_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= '0;
            ir  <= '0;
            a   <= '0;
            b   <= '0;
            acc <= '0;
            o   <= '0;
            z   <= 1'b0;
            c   <= 1'b0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir <= instrData;
                    pc <= pc + ADDR_WIDTH'(1);
                end
                S_EXEC: begin
                    if (alu_we) begin
                        acc <= alu_res;
                        z   <= (alu_res == '0);
                    end
                    if (c_we) c <= alu_c;
                    if (opcode == OP_OUT) o <= acc;
                    if (opcode == OP_JMP || (opcode == OP_JNZ && !z)) pc <= operand;
                end
                S_WAIT_IN: begin
                    if (inValid) begin
                        if (opcode == OP_LDB) b <= inData;
                        else                  a <= inData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aeolus_multicycle_core.sv
// Directed self-checking bench for aeolus_multicycle_core with a synchronous ROM model.
// Build with AEOLUS_SINGLE_STEP_EN defined to also exercise single-step gating.
module tb_aeolus_multicycle_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] instrAddr;
    logic [8:0] instrData = '0;
    logic [7:0] inData = '0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady = 1'b0;
    logic       halted;
`ifdef AEOLUS_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] rom [32];

    always #5 clk = ~clk;

    always @(posedge clk) instrData <= rom[instrAddr];

    aeolus_multicycle_core #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .INSTR_WIDTH(9)) dut (
        .clk(clk),
        .reset(reset),
`ifdef AEOLUS_SINGLE_STEP_EN
        .step(step),
`endif
        .instrAddr(instrAddr),
        .instrData(instrData),
        .inData(inData),
        .inValid(inValid),
        .inReady(inReady),
        .outData(outData),
        .outValid(outValid),
        .outReady(outReady),
        .halted(halted)
    );

    function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] opd);
        return {op, opd};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = mk(4'h0, 5'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_inready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (inReady) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = mk(4'h3, 5'd5);
        rom[1] = mk(4'hC, 5'd0);
        outReady = 1'b0;
        do_reset();
        tick(6);
        checks++;
        if (outValid !== 1'b1 || outData !== 8'h05) begin
            errors++;
            $display("FAIL reset_pre_out outValid=%b outData=%h want 1/05", outValid, outData);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (outValid !== 1'b0 || instrAddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_first outValid=%b instrAddr=%0d want 0/0", outValid, instrAddr);
        end
        tick(1);
        checks++;
        if (dut.pc !== 5'd0 || dut.ir !== 9'd0 || dut.a !== 8'd0 || dut.b !== 8'd0 ||
            dut.acc !== 8'd0 || outData !== 8'd0 || dut.z !== 1'b0 || dut.c !== 1'b0 ||
            inReady !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs pc=%0d ir=%h a=%h b=%h acc=%h o=%h z=%b c=%b inReady=%b halted=%b want all 0",
                     dut.pc, dut.ir, dut.a, dut.b, dut.acc, outData, dut.z, dut.c, inReady, halted);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith();
        bit ok;
        clear_rom();
        rom[0] = mk(4'h1, 5'd0);
        rom[1] = mk(4'h2, 5'd0);
        rom[2] = mk(4'h4, 5'd0);
        rom[3] = mk(4'hC, 5'd0);
        rom[4] = mk(4'h1, 5'd0);
        rom[5] = mk(4'h5, 5'd0);
        rom[6] = mk(4'hF, 5'd0);
        outReady = 1'b1;
        do_reset();
        wait_inready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL arith_lda_wait inReady=%b want 1", inReady); end
        inData = 8'hF0; inValid = 1'b1; tick(1); inValid = 1'b0;
        wait_inready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL arith_ldb_wait inReady=%b want 1", inReady); end
        inData = 8'h20; inValid = 1'b1; tick(1); inValid = 1'b0;
        tick(3);
        checks++;
        if (dut.acc !== 8'h10 || dut.c !== 1'b1 || dut.z !== 1'b0) begin
            errors++;
            $display("FAIL arith_add acc=%h c=%b z=%b want 10/1/0", dut.acc, dut.c, dut.z);
        end
        tick(3);
        checks++;
        if (outValid !== 1'b1 || outData !== 8'h10) begin
            errors++;
            $display("FAIL arith_out outValid=%b outData=%h want 1/10", outValid, outData);
        end
        tick(1);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL arith_out_drop outValid=%b want 0", outValid);
        end
        wait_inready(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL arith_lda2_wait inReady=%b want 1", inReady); end
        inData = 8'h20; inValid = 1'b1; tick(1); inValid = 1'b0;
        tick(3);
        checks++;
        if (dut.acc !== 8'h00 || dut.z !== 1'b1 || dut.c !== 1'b0) begin
            errors++;
            $display("FAIL arith_sub acc=%h z=%b c=%b want 00/1/0", dut.acc, dut.z, dut.c);
        end
        tick(3);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL arith_halt halted=%b want 1", halted);
        end
        outReady = 1'b0;
    endtask

    task automatic test_branch();
        clear_rom();
        rom[0]  = mk(4'h3, 5'd3);
        rom[1]  = mk(4'hA, 5'd0);
        rom[2]  = mk(4'hE, 5'd5);
        rom[5]  = mk(4'h3, 5'd0);
        rom[6]  = mk(4'hE, 5'd10);
        rom[7]  = mk(4'hD, 5'd31);
        rom[31] = mk(4'hD, 5'd0);
        do_reset();
        tick(9);
        checks++;
        if (dut.pc !== 5'd5 || dut.acc !== 8'h06 || dut.c !== 1'b0) begin
            errors++;
            $display("FAIL branch_jnz_taken pc=%0d acc=%h c=%b want 5/06/0", dut.pc, dut.acc, dut.c);
        end
        tick(6);
        checks++;
        if (dut.pc !== 5'd7 || dut.z !== 1'b1) begin
            errors++;
            $display("FAIL branch_jnz_fall pc=%0d z=%b want 7/1", dut.pc, dut.z);
        end
        tick(3);
        checks++;
        if (instrAddr !== 5'd31) begin
            errors++;
            $display("FAIL branch_jmp31 instrAddr=%0d want 31", instrAddr);
        end
        tick(3);
        checks++;
        if (instrAddr !== 5'd0) begin
            errors++;
            $display("FAIL branch_jmp0 instrAddr=%0d want 0", instrAddr);
        end
    endtask

    task automatic test_handshake();
        clear_rom();
        rom[0] = mk(4'h3, 5'd9);
        rom[1] = mk(4'h1, 5'd0);
        rom[2] = mk(4'hC, 5'd0);
        rom[3] = mk(4'hF, 5'd0);
        inValid = 1'b0;
        outReady = 1'b0;
        do_reset();
        tick(6);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (inReady !== 1'b1 || dut.a !== 8'h00) begin
                errors++;
                $display("FAIL hs_wait_in[%0d] inReady=%b a=%h want 1/00", i, inReady, dut.a);
            end
            tick(1);
        end
        inData = 8'h5A; inValid = 1'b1; tick(1); inValid = 1'b0;
        checks++;
        if (dut.a !== 8'h5A || inReady !== 1'b0) begin
            errors++;
            $display("FAIL hs_accept a=%h inReady=%b want 5A/0", dut.a, inReady);
        end
        tick(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outValid !== 1'b1 || outData !== 8'h09) begin
                errors++;
                $display("FAIL hs_wait_out[%0d] outValid=%b outData=%h want 1/09", i, outValid, outData);
            end
            tick(1);
        end
        outReady = 1'b1; tick(1); outReady = 1'b0;
        checks++;
        if (outValid !== 1'b0 || outData !== 8'h09) begin
            errors++;
            $display("FAIL hs_out_done outValid=%b outData=%h want 0/09", outValid, outData);
        end
    endtask

    task automatic test_wrap_halt();
        clear_rom();
        rom[0]  = mk(4'hD, 5'd30);
        rom[30] = mk(4'h3, 5'd12);
        rom[31] = mk(4'h0, 5'd0);
        do_reset();
        tick(6);
        checks++;
        if (dut.acc !== 8'h0C || dut.pc !== 5'd31) begin
            errors++;
            $display("FAIL wrap_pre acc=%h pc=%0d want 0C/31", dut.acc, dut.pc);
        end
        tick(3);
        checks++;
        if (instrAddr !== 5'd0) begin
            errors++;
            $display("FAIL wrap_nop31 instrAddr=%0d want 0", instrAddr);
        end
        clear_rom();
        rom[0] = mk(4'h3, 5'd5);
        rom[1] = mk(4'hF, 5'd0);
        rom[2] = mk(4'h3, 5'd1);
        do_reset();
        tick(6);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (halted !== 1'b1 || dut.acc !== 8'h05 || dut.pc !== 5'd2 || instrAddr !== 5'd2 ||
                outValid !== 1'b0 || inReady !== 1'b0) begin
                errors++;
                $display("FAIL halt_frozen[%0d] halted=%b acc=%h pc=%0d outValid=%b inReady=%b want 1/05/2/0/0",
                         i, halted, dut.acc, dut.pc, outValid, inReady);
            end
            tick(1);
        end
    endtask

`ifdef AEOLUS_SINGLE_STEP_EN
    task automatic test_single_step();
        clear_rom();
        rom[0] = mk(4'h3, 5'd1);
        rom[1] = mk(4'h3, 5'd2);
        rom[2] = mk(4'h3, 5'd3);
        rom[3] = mk(4'h3, 5'd4);
        step = 1'b0;
        do_reset();
        tick(5);
        checks++;
        if (dut.pc !== 5'd0 || instrAddr !== 5'd0) begin
            errors++;
            $display("FAIL step_hold pc=%0d want 0", dut.pc);
        end
        for (int k = 1; k <= 4; k++) begin
            step = 1'b1; tick(1); step = 1'b0; tick(3);
            checks++;
            if (dut.pc !== 5'(k) || dut.acc !== 8'(k)) begin
                errors++;
                $display("FAIL step_pulse[%0d] pc=%0d acc=%h want %0d", k, dut.pc, dut.acc, k);
            end
        end
        step = 1'b1;
    endtask
`endif

    initial begin
        clear_rom();
        test_reset();
        test_arith();
        test_branch();
        test_handshake();
        test_wrap_halt();
`ifdef AEOLUS_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
